// File: rtl/alu_exec_if.sv
// Handshake bundle between decode/register-fetch, the execute unit and writeback.
// The unit takes the slave side; the upstream/downstream pair takes the master side.
interface alu_exec_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_alt;
    logic             in_branch;
    logic             in_mul;
    logic [XLEN-1:0]  in_x;
    logic [XLEN-1:0]  in_y;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic             out_taken;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_alt, in_branch, in_mul, in_x, in_y, in_tag,
        output flush, out_ready,
        input  in_ready, out_valid, out_result, out_taken, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_alt, in_branch, in_mul, in_x, in_y, in_tag,
        input  flush, out_ready,
        output in_ready, out_valid, out_result, out_taken, out_tag
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Pipelined integer ALU / branch-compare execute unit with valid/ready on both sides.
// Define ALU_MUL_EN to add the iterative XLEN-cycle shift-add multiplier (M ops).
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic       clk,
    input  logic       resetn,
    alu_exec_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    logic [STAGES-1:0] st_valid;
    logic [XLEN-1:0]   st_result [STAGES];
    logic              st_taken  [STAGES];
    logic [TAG_W-1:0]  st_tag    [STAGES];
    logic [STAGES-1:0] st_moves;
    logic [STAGES-1:0] st_load;

    logic              accept;
    logic              is_mul_op;
    logic              mul_busy;
    logic              mul_fin;
    logic [XLEN-1:0]   mul_res;
    logic [TAG_W-1:0]  mul_tag;

    // Ready ripples backwards from the consumer so bubbles collapse in one edge.
    always_comb begin
        logic nxt_ready;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        st_moves  = '0;
        st_load   = '0;
        nxt_ready = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            st_moves[k] = st_valid[k] && nxt_ready;
            st_load[k]  = !st_valid[k] || st_moves[k];
            nxt_ready   = st_load[k];
        end
    end

    assign bus.in_ready = !bus.flush && st_load[0] && !mul_busy;
    assign accept       = bus.in_valid && bus.in_ready;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            br_taken;

    assign shamt = bus.in_y[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        br_taken = 1'b0;
        if (bus.in_branch) begin
            case (bus.in_funct3)
                3'b000:  br_taken = (bus.in_x == bus.in_y);
                3'b001:  br_taken = (bus.in_x != bus.in_y);
                3'b100:  br_taken = ($signed(bus.in_x) <  $signed(bus.in_y));
                3'b101:  br_taken = ($signed(bus.in_x) >= $signed(bus.in_y));
                3'b110:  br_taken = (bus.in_x <  bus.in_y);
                3'b111:  br_taken = (bus.in_x >= bus.in_y);
                default: br_taken = 1'b0;
            endcase
        end else begin
            case (bus.in_funct3)
                3'b000:  alu_res = bus.in_alt ? (bus.in_x - bus.in_y) : (bus.in_x + bus.in_y);
                3'b001:  alu_res = bus.in_x << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_x) < $signed(bus.in_y))};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, (bus.in_x < bus.in_y)};
                3'b100:  alu_res = bus.in_x ^ bus.in_y;
                3'b101:  alu_res = bus.in_alt ? XLEN'($signed(bus.in_x) >>> shamt)
                                              : (bus.in_x >> shamt);
                3'b110:  alu_res = bus.in_x | bus.in_y;
                default: alu_res = bus.in_x & bus.in_y;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  mul_cnt;
    logic [2*XLEN-1:0] mul_acc;
    logic [2*XLEN-1:0] mul_mcand;
    logic [XLEN-1:0]   mul_mplier;
    logic              mul_neg;
    logic [2:0]        mul_f3;
    logic [2*XLEN-1:0] mul_step;
    logic [2*XLEN-1:0] mul_prod_u;
    logic [2*XLEN-1:0] mul_prod;
    logic              x_sgn, y_sgn, x_neg, y_neg;
    logic [XLEN-1:0]   x_mag, y_mag;

    assign is_mul_op = bus.in_mul && !bus.in_branch;

    // Signed variants multiply magnitudes and fix the sign of the full product at the end.
    always_comb begin
        x_sgn = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b010);
        y_sgn = (bus.in_funct3 == 3'b001);
        x_neg = x_sgn && bus.in_x[XLEN-1];
        y_neg = y_sgn && bus.in_y[XLEN-1];
        x_mag = x_neg ? -bus.in_x : bus.in_x;
        y_mag = y_neg ? -bus.in_y : bus.in_y;
    end

    // The final partial product is folded in combinationally on the edge the result
    // leaves, unless stage 0 is blocked, in which case it is registered and held.
    assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_fin  = mul_busy && (mul_cnt >= CNT_W'(XLEN - 1));

    always_comb begin
        mul_prod_u = (mul_cnt == CNT_W'(XLEN)) ? mul_acc : mul_step;
        mul_prod   = mul_neg ? -mul_prod_u : mul_prod_u;
        case (mul_f3)
            3'b000:                 mul_res = mul_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mul_res = mul_prod[2*XLEN-1:XLEN];
            default:                mul_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_busy   <= 1'b0;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_neg    <= 1'b0;
            mul_f3     <= '0;
            mul_tag    <= '0;
        end else if (bus.flush) begin
            mul_busy <= 1'b0;
        end else if (accept && is_mul_op) begin
            mul_busy   <= 1'b1;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= {{XLEN{1'b0}}, x_mag};
            mul_mplier <= y_mag;
            mul_neg    <= x_neg ^ y_neg;
            mul_f3     <= bus.in_funct3;
            mul_tag    <= bus.in_tag;
        end else if (mul_busy) begin
            if (mul_fin && st_load[0]) begin
                mul_busy <= 1'b0;
            end else if (mul_cnt != CNT_W'(XLEN)) begin
                mul_acc    <= mul_step;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_mul;

    assign unused_mul = bus.in_mul;
    assign is_mul_op  = 1'b0;
    assign mul_busy   = 1'b0;
    assign mul_fin    = 1'b0;
    assign mul_res    = '0;
    assign mul_tag    = '0;
`endif

    // NOTE: stage data registers are reset too, because out_* must read zero in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: sequential state uses non-blocking assignments only.
                st_valid[k]  <= 1'b0;
                st_result[k] <= '0;
                st_taken[k]  <= 1'b0;
                st_tag[k]    <= '0;
            end
        end else if (bus.flush) begin
            st_valid <= '0;
        end else begin
            if (st_load[0]) begin
                if (mul_fin) begin
                    st_valid[0]  <= 1'b1;
                    st_result[0] <= mul_res;
                    st_taken[0]  <= 1'b0;
                    st_tag[0]    <= mul_tag;
                end else if (accept && !is_mul_op) begin
                    st_valid[0]  <= 1'b1;
                    st_result[0] <= alu_res;
                    st_taken[0]  <= br_taken;
                    st_tag[0]    <= bus.in_tag;
                end else begin
                    st_valid[0]  <= 1'b0;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (st_load[k]) begin
                    st_valid[k]  <= st_valid[k-1];
                    st_result[k] <= st_result[k-1];
                    st_taken[k]  <= st_taken[k-1];
                    st_tag[k]    <= st_tag[k-1];
                end
            end
        end
    end

    assign bus.out_valid  = st_valid[STAGES-1];
    assign bus.out_result = st_result[STAGES-1];
    assign bus.out_taken  = st_taken[STAGES-1];
    assign bus.out_tag    = st_tag[STAGES-1];
endmodule
